// File: rtl/aes_dec_pkg.sv
// Shared encodings for the AES-128 inverse round sequencer.
// Optional abort input enabled by AES_INV_CTRL_ABORT_EN.
package aes_dec_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADD    = 3'd1;
  localparam logic [2:0] S_ISHIFT = 3'd2;
  localparam logic [2:0] S_ISUB   = 3'd3;
  localparam logic [2:0] S_IMIX   = 3'd4;
  localparam logic [2:0] S_KEY    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] KSEL_EXT  = 2'b00;
  localparam logic [1:0] KSEL_REG  = 2'b01;
  localparam logic [1:0] KSEL_HOLD = 2'b10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef struct packed {
    logic        add;
    logic        sub;
    logic        shift;
    logic        mix;
    logic        key;
    logic [31:0] rc;
    logic        data_sel;
    logic [1:0]  key_sel;
    logic        busy;
    logic        done;
  } ctrl_out_t;

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Decrypt handshake and datapath/key strobe bundle.
// abort exists only with AES_INV_CTRL_ABORT_EN.
interface aes_inv_round_ctrl_if;
  logic        start;
`ifdef AES_INV_CTRL_ABORT_EN
  logic        abort;
`endif
  logic        add_start;
  logic        inv_sub_start;
  logic        inv_shift_start;
  logic        inv_mix_start;
  logic        key_start;
  logic [31:0] key_RC;
  logic        data_sel;
  logic [1:0]  key_sel;
  logic [3:0]  round;
  logic        busy;
  logic        dec_done;

  modport master (
    input  start,
`ifdef AES_INV_CTRL_ABORT_EN
    input  abort,
`endif
    output add_start, inv_sub_start,
    output inv_shift_start, inv_mix_start,
    output key_start, key_RC,
    output data_sel, key_sel, round,
    output busy, dec_done
  );

  modport slave (
    output start,
`ifdef AES_INV_CTRL_ABORT_EN
    output abort,
`endif
    input  add_start, inv_sub_start,
    input  inv_shift_start, inv_mix_start,
    input  key_start, key_RC,
    input  data_sel, key_sel, round,
    input  busy, dec_done
  );
endinterface

// File: rtl/aes_rcon_rom.sv
// Round constant lookup for rounds 1..10.
// Out-of-range rounds return zero.
module aes_rcon_rom
  import aes_dec_pkg::*;
(
  input  logic [3:0] round,
  output logic [7:0] rcon
);

  always_comb begin
    rcon = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (round == 4'(i)) rcon = RCON[i];
    end
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 inverse cipher round sequencer, registered outputs.
// Optional abort input enabled by AES_INV_CTRL_ABORT_EN.
module aes_inv_round_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR = 10
) (
  input logic               clk,
  input logic               reset_n,
  aes_inv_round_ctrl_if.master bus
);

  localparam logic [3:0] NR4 = 4'(NR);

  logic [2:0] state, state_n;
  logic [3:0] r, r_n;
  logic [7:0] rc;
  ctrl_out_t  o, o_n;

  // Outputs are decoded from the next state so they align with it.
  aes_rcon_rom u_rcon (
    .round (r_n),
    .rcon  (rc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      r     <= 4'd0;
      o     <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      o     <= o_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_ADD;
          r_n     = NR4;
        end
      end
      S_ADD: begin
        if (r == NR4)       state_n = S_KEY;
        else if (r == 4'd0) state_n = S_DONE;
        else                state_n = S_IMIX;
      end
      S_IMIX:   state_n = S_KEY;
      S_KEY: begin
        state_n = S_ISHIFT;
        r_n     = r - 4'd1;
      end
      S_ISHIFT: state_n = S_ISUB;
      S_ISUB:   state_n = S_ADD;
      S_DONE:   state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        r_n     = 4'd0;
      end
    endcase
`ifdef AES_INV_CTRL_ABORT_EN
    if (bus.abort && state != S_IDLE) begin
      state_n = S_IDLE;
      r_n     = 4'd0;
    end
`endif
  end

  always_comb begin
    o_n = '0;
    unique case (state_n)
      S_ADD: begin
        o_n.add  = 1'b1;
        o_n.busy = 1'b1;
        if (r_n == NR4) begin
          o_n.data_sel = 1'b0;
          o_n.key_sel  = KSEL_EXT;
        end else begin
          o_n.data_sel = 1'b1;
          o_n.key_sel  = KSEL_REG;
        end
      end
      S_IMIX, S_ISHIFT, S_ISUB, S_KEY: begin
        o_n.busy     = 1'b1;
        o_n.data_sel = 1'b1;
        o_n.key_sel  = KSEL_REG;
        o_n.mix      = (state_n == S_IMIX);
        o_n.shift    = (state_n == S_ISHIFT);
        o_n.sub      = (state_n == S_ISUB);
        o_n.key      = (state_n == S_KEY);
        if (state_n == S_KEY) o_n.rc = {rc, 24'h0};
      end
      S_DONE: begin
        o_n.busy     = 1'b1;
        o_n.done     = 1'b1;
        o_n.data_sel = 1'b1;
        o_n.key_sel  = KSEL_HOLD;
      end
      default: o_n = '0;
    endcase
  end

  assign bus.add_start       = o.add;
  assign bus.inv_sub_start   = o.sub;
  assign bus.inv_shift_start = o.shift;
  assign bus.inv_mix_start   = o.mix;
  assign bus.key_start       = o.key;
  assign bus.key_RC          = o.rc;
  assign bus.data_sel        = o.data_sel;
  assign bus.key_sel         = o.key_sel;
  assign bus.round           = r;
  assign bus.busy            = o.busy;
  assign bus.dec_done        = o.done;

endmodule
